// File: rtl/priority_grant_ctrl_if.sv
// Arbiter/source-facing bundle for priority_grant_ctrl: arbiter winner in, grant/release/revoke out.
interface priority_grant_ctrl_if #(
  parameter int N         = 8,
  parameter int PRIO_BITS = 3,
  parameter int SEL_W     = $clog2(N)
);
  logic                 arb_req_i;
  logic [SEL_W-1:0]     arb_sel_i;
  logic [PRIO_BITS-1:0] arb_prio_i;
  logic [N-1:0]         done_i;
  logic [N-1:0]         gnt_o;
  logic                 gnt_valid_o;
  logic [SEL_W-1:0]     gnt_sel_o;
  logic [PRIO_BITS-1:0] gnt_prio_o;
  logic                 timeout_o;
  logic [N-1:0]         revoke_o;

  modport master (
    output arb_req_i, arb_sel_i, arb_prio_i, done_i,
    input  gnt_o, gnt_valid_o, gnt_sel_o, gnt_prio_o, timeout_o, revoke_o
  );

  modport slave (
    input  arb_req_i, arb_sel_i, arb_prio_i, done_i,
    output gnt_o, gnt_valid_o, gnt_sel_o, gnt_prio_o, timeout_o, revoke_o
  );
endinterface

// File: rtl/priority_grant_ctrl.sv
// Grant side of the priority arbitration path: registers the arbiter winner, holds a one-hot grant
// until done or hold timeout, then inserts one dead cycle. Optional preemption via PRIO_PREEMPT_EN.
module priority_grant_ctrl #(
  parameter int N         = 8,
  parameter int PRIO_BITS = 3,
  parameter int SEL_W     = $clog2(N),
  parameter int MAX_HOLD  = 255
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  priority_grant_ctrl_if.slave  bus
);

  localparam int          HCW         = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int unsigned HOLD_LAST_I = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  localparam logic [HCW-1:0]  HOLD_LAST = HCW'(HOLD_LAST_I);
  localparam logic [SEL_W:0]  N_LIM     = (SEL_W + 1)'(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_RELEASE
`ifdef PRIO_PREEMPT_EN
    , S_REVOKE
`endif
  } state_t;

  state_t               state;
  logic [SEL_W-1:0]     sel_q;
  logic [PRIO_BITS-1:0] prio_q;
  logic [HCW-1:0]       hold_cnt;
  logic [N-1:0]         gnt_q;
  logic                 valid_q;
  logic                 timeout_q;

  logic sel_ok;
  logic done_hit;
  logic hold_expired;
  logic holding;

  function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

`ifdef PRIO_PREEMPT_EN
  logic [N-1:0] revoke_q;
  logic         preempt_hit;

  always_comb begin
    preempt_hit = bus.arb_req_i && (bus.arb_prio_i < prio_q) && (bus.arb_sel_i != sel_q);
  end
`endif

  always_comb begin
    // Indices past N can appear when N is not a power of two; they are not requests.
    sel_ok       = {1'b0, bus.arb_sel_i} < N_LIM;
    done_hit     = bus.done_i[sel_q];
    hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
`ifdef PRIO_PREEMPT_EN
    holding      = (state == S_GRANT) || (state == S_REVOKE);
`else
    holding      = (state == S_GRANT);
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= S_IDLE;
      sel_q     <= '0;
      prio_q    <= '0;
      hold_cnt  <= '0;
      gnt_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
`ifdef PRIO_PREEMPT_EN
      revoke_q  <= '0;
`endif
    end else begin
      timeout_q <= 1'b0;
      if (state == S_IDLE) begin
        if (bus.arb_req_i && sel_ok) begin
          state    <= S_GRANT;
          sel_q    <= bus.arb_sel_i;
          prio_q   <= bus.arb_prio_i;
          hold_cnt <= '0;
          gnt_q    <= onehot(bus.arb_sel_i);
          valid_q  <= 1'b1;
        end
      end else if (holding) begin
        if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
        // Done takes precedence over an expiring hold, so timeout only fires without done.
        if (done_hit || hold_expired) begin
          state     <= S_RELEASE;
          gnt_q     <= '0;
          valid_q   <= 1'b0;
          timeout_q <= !done_hit;
`ifdef PRIO_PREEMPT_EN
          revoke_q  <= '0;
`endif
        end
`ifdef PRIO_PREEMPT_EN
        else if ((state == S_GRANT) && preempt_hit) begin
          state    <= S_REVOKE;
          revoke_q <= gnt_q;
        end
`endif
      end else begin
        state <= S_IDLE;
      end
    end
  end

  assign bus.gnt_o       = gnt_q;
  assign bus.gnt_valid_o = valid_q;
  assign bus.gnt_sel_o   = sel_q;
  assign bus.gnt_prio_o  = prio_q;
  assign bus.timeout_o   = timeout_q;
`ifdef PRIO_PREEMPT_EN
  assign bus.revoke_o    = revoke_q;
`else
  assign bus.revoke_o    = '0;
`endif

endmodule
